piso_sipo_shift_register: RTL and testbench

//   Parametrised universal shift register: hold, shift right, shift left and parallel load.

---
 rtl/piso_sipo_shift_register.sv | 95 +++++++++
 tb/tb_piso_sipo_shift_register.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_sipo_shift_register.sv
// Universal shift register: hold, shift right/left (fill or rotate) and parallel load.
// Shift counter and frame_done pulse flag every completed WIDTH-shift frame.
module piso_sipo_shift_register #(
   parameter int                  WIDTH     = 8,
   parameter bit                  ROTATE    = 1'b0,
   parameter logic [WIDTH-1:0]    RESET_VAL = {WIDTH{1'b0}},
   localparam int                 CW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pdata,
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CW-1:0]    shift_cnt,
   output logic             frame_done
);

   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fd_q, fd_d;
   logic             shift_s;
   logic             fill_r_s, fill_l_s;

   // In rotate mode the bit leaving one end re-enters at the other.
   assign fill_r_s = ROTATE ? q_q[0]       : sin_r;
   assign fill_l_s = ROTATE ? q_q[WIDTH-1] : sin_l;

   // Next-state for data register, shift counter and frame pulse
   always_comb begin
      q_d     = q_q;
      cnt_d   = cnt_q;
      fd_d    = 1'b0;
      shift_s = 1'b0;
      if (en) begin
         case (mode)
            2'b01: begin
               q_d     = {fill_r_s, q_q[WIDTH-1:1]};
               shift_s = 1'b1;
            end
            2'b10: begin
               q_d     = {q_q[WIDTH-2:0], fill_l_s};
               shift_s = 1'b1;
            end
            2'b11: begin
               q_d   = pdata;
               cnt_d = CNT_ZERO;
            end
            default: begin
               q_d = q_q;
            end
         endcase
      end else begin
         q_d = q_q;
      end
      if (shift_s) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d = CNT_ZERO;
            fd_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         fd_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q   <= RESET_VAL;
         cnt_q <= CNT_ZERO;
         fd_q  <= 1'b0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
         fd_q  <= fd_d;
      end
   end

   assign q          = q_q;
   assign shift_cnt  = cnt_q;
   assign frame_done = fd_q;
   assign sout_r     = q_q[0];
   assign sout_l     = q_q[WIDTH-1];

endmodule

// File: tb/tb_piso_sipo_shift_register.sv
// Bench for piso_sipo_shift_register: three instances (W8 fill, W8 rotate, W4 fill) sharing
// stimulus, directed vector table, hand-written corner sequences and randomized model checking.
module tb_piso_sipo_shift_register;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       sin_r;
   logic       sin_l;
   logic [7:0] pdata;

   logic [7:0] q8,   q8r;
   logic [3:0] cnt8, cnt8r;
   logic       fd8,  fd8r, sr8, sl8, sr8r, sl8r;
   logic [3:0] q4;
   logic [2:0] cnt4;
   logic       fd4, sr4, sl4;

   int checks   = 0;
   int failures = 0;

   piso_sipo_shift_register #(.WIDTH(8), .ROTATE(1'b0)) u8 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
      .pdata(pdata), .q(q8), .sout_r(sr8), .sout_l(sl8), .shift_cnt(cnt8), .frame_done(fd8));

   piso_sipo_shift_register #(.WIDTH(8), .ROTATE(1'b1)) u8r (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
      .pdata(pdata), .q(q8r), .sout_r(sr8r), .sout_l(sl8r), .shift_cnt(cnt8r), .frame_done(fd8r));

   piso_sipo_shift_register #(.WIDTH(4), .ROTATE(1'b0)) u4 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
      .pdata(pdata[3:0]), .q(q4), .sout_r(sr4), .sout_l(sl4), .shift_cnt(cnt4), .frame_done(fd4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: register value as an integer, shift count modulo width
   int unsigned mq[3];
   int unsigned mcnt[3];
   bit          mfd[3];
   int unsigned mw[3]  = '{8, 8, 4};
   bit          mrot[3] = '{1'b0, 1'b1, 1'b0};

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i] = 0; mcnt[i] = 0; mfd[i] = 1'b0;
      end
   endfunction

   function automatic void model_edge();
      for (int i = 0; i < 3; i++) begin
         int unsigned mask;
         int unsigned out_bit;
         int unsigned in_bit;
         bit          shifted;
         mask    = (1 << mw[i]) - 1;
         shifted = 1'b0;
         mfd[i]  = 1'b0;
         if (en) begin
            if (mode == 2'd1) begin
               out_bit = mq[i] % 2;
               in_bit  = mrot[i] ? out_bit : int'(sin_r);
               mq[i]   = (mq[i] / 2) + in_bit * (1 << (mw[i] - 1));
               shifted = 1'b1;
            end else if (mode == 2'd2) begin
               out_bit = (mq[i] >> (mw[i] - 1)) % 2;
               in_bit  = mrot[i] ? out_bit : int'(sin_l);
               mq[i]   = (mq[i] * 2 + in_bit) & mask;
               shifted = 1'b1;
            end else if (mode == 2'd3) begin
               mq[i]   = int'(pdata) & mask;
               mcnt[i] = 0;
            end
            if (shifted) begin
               mcnt[i] = mcnt[i] + 1;
               if (mcnt[i] == mw[i]) begin
                  mcnt[i] = 0;
                  mfd[i]  = 1'b1;
               end
            end
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic chk_inst(input string tag, input int i, input logic [7:0] aq,
                           input logic [3:0] acnt, input logic afd, input logic asr, input logic asl);
      chk({tag, ".q"},      32'(aq),   mq[i]);
      chk({tag, ".cnt"},    32'(acnt), mcnt[i]);
      chk({tag, ".fd"},     32'(afd),  32'(mfd[i]));
      chk({tag, ".sout_r"}, 32'(asr),  mq[i] % 2);
      chk({tag, ".sout_l"}, 32'(asl),  (mq[i] >> (mw[i] - 1)) % 2);
   endtask

   task automatic check_model(input string tag);
      chk_inst({tag, ":w8"},  0, q8,  cnt8,  fd8,  sr8,  sl8);
      chk_inst({tag, ":w8r"}, 1, q8r, cnt8r, fd8r, sr8r, sl8r);
      chk_inst({tag, ":w4"},  2, {4'h0, q4}, {1'b0, cnt4}, fd4, sr4, sl4);
   endtask

   // Apply inputs, clock one edge, update model, return at the following falling edge
   task automatic step(input logic e, input logic [1:0] m, input logic sr,
                       input logic sl, input logic [7:0] pd);
      en = e; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic       sin_r;
      logic       sin_l;
      logic [7:0] pdata;
      logic       pre_sr;
      logic [7:0] exp_q;
      logic [3:0] exp_cnt;
      logic       exp_fd;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                               input logic [7:0] pd, input logic pre, input logic [7:0] eq,
                               input logic [3:0] ec, input logic ef);
      vec_t v;
      v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl; v.pdata = pd;
      v.pre_sr = pre; v.exp_q = eq; v.exp_cnt = ec; v.exp_fd = ef;
      return v;
   endfunction

   initial begin
      // Load A5 and shift it out to the right; then build 0D by left shifts; then enable freeze
      vt.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 8'hA5, 1'b0, 8'hA5, 4'd0, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h52, 4'd1, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h29, 4'd2, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h14, 4'd3, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h0A, 4'd4, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 4'd5, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 4'd6, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 4'd7, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 4'd0, 1'b1));
      vt.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0));
      vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 4'd1, 1'b0));
      vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b1, 8'h03, 4'd2, 1'b0));
      vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 8'h06, 4'd3, 1'b0));
      vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0, 8'h0D, 4'd4, 1'b0));
      vt.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b1, 8'h3C, 4'd0, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 8'h9E, 4'd1, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 8'hCF, 4'd2, 1'b0));
      vt.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b1, 8'hE7, 4'd3, 1'b0));
      vt.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 8'hE7, 4'd3, 1'b0));
      vt.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1, 8'hE7, 4'd3, 1'b0));
      vt.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hFF, 4'd0, 1'b0));

      rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pdata = 8'h00;
      model_reset();
      #2;
      check_model("reset");
      @(negedge clk);
      rst = 1'b1;

      foreach (vt[k]) begin
         chk($sformatf("vec%0d.pre_sout_r", k), 32'(sr8), 32'(vt[k].pre_sr));
         step(vt[k].en, vt[k].mode, vt[k].sin_r, vt[k].sin_l, vt[k].pdata);
         chk($sformatf("vec%0d.q", k),   32'(q8),   32'(vt[k].exp_q));
         chk($sformatf("vec%0d.cnt", k), 32'(cnt8), 32'(vt[k].exp_cnt));
         chk($sformatf("vec%0d.fd", k),  32'(fd8),  32'(vt[k].exp_fd));
         check_model($sformatf("vec%0d", k));
      end

      // Async reset mid-frame, held across edges
      for (int k = 0; k < 3; k++) step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
      chk("pre_reset.cnt", 32'(cnt8), 32'd3);
      #1 rst = 1'b0;
      #1;
      model_reset();
      chk("async_reset.q", 32'(q8), 32'h0);
      chk("async_reset.cnt", 32'(cnt8), 32'h0);
      chk("async_reset.fd", 32'(fd8), 32'h0);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         en = 1'b1; mode = 2'b11; pdata = 8'h5A;
         @(posedge clk);
         @(negedge clk);
         check_model($sformatf("reset_hold%0d", k));
      end
      rst = 1'b1;

      // Rotate: load 81, one left shift gives 03, eight total restores 81 with one pulse
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'h81);
      step(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
      chk("rot.q1", 32'(q8r), 32'h03);
      for (int k = 2; k <= 8; k++) begin
         step(1'b1, 2'b10, 1'b0, 1'b0, 8'h00);
         chk($sformatf("rot.fd%0d", k), 32'(fd8r), (k == 8) ? 32'd1 : 32'd0);
         check_model($sformatf("rot%0d", k));
      end
      chk("rot.q8", 32'(q8r), 32'h81);
      step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
      chk("rot.fd_after", 32'(fd8r), 32'd0);

      // Width 4: load 9, four right shifts of ones gives F, pulse after the fourth only
      step(1'b1, 2'b11, 1'b0, 1'b0, 8'h09);
      chk("w4.load", 32'(q4), 32'h9);
      for (int k = 1; k <= 4; k++) begin
         step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
         chk($sformatf("w4.fd%0d", k), 32'(fd4), (k == 4) ? 32'd1 : 32'd0);
      end
      chk("w4.q", 32'(q4), 32'hF);
      chk("w4.cnt", 32'(cnt4), 32'h0);
      step(1'b1, 2'b00, 1'b0, 1'b0, 8'h00);
      chk("w4.hold_q", 32'(q4), 32'hF);
      chk("w4.hold_fd", 32'(fd4), 32'h0);
      check_model("w4.end");

      // Randomized traffic, with occasional asynchronous reset between edges
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 59) == 0) begin
            #1 rst = 1'b0;
            #1;
            model_reset();
            check_model($sformatf("rnd_rst%0d", k));
            rst = 1'b1;
         end
         step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
              1'($urandom), 1'($urandom), 8'($urandom));
         check_model($sformatf("rnd%0d", k));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
